// File: rtl/amq_ctrl_pkg.sv
// Shared types for the add/sub-mod-Q sequencer: command encodings,
// controller states, latched command payload and address widths.
package amq_ctrl_pkg;

    localparam int unsigned NW_DEFAULT = 4;
    localparam int unsigned WADDR_W    = 2;
    localparam int unsigned OFF_W      = 3;
    localparam int unsigned QADDR_W    = 5;
    localparam int unsigned OP_W       = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 2'b00,
        OP_ADDQ = 2'b01,
        OP_SUBQ = 2'b10,
        OP_SWAP = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLR   = 3'd2,
        ST_FETCH = 3'd3,
        ST_ACC   = 3'd4,
        ST_WB    = 3'd5,
        ST_FIN   = 3'd6
    } state_e;

    // Command fields captured at accept and held for the whole command.
    typedef struct packed {
        cmd_op_e              op;
        logic [OFF_W-1:0]     rd_off;
        logic [OFF_W-1:0]     wr_off;
        logic [QADDR_W-1:0]   q_base;
    } cmd_t;

endpackage

// File: rtl/amq_word_cnt.sv
// Word index counter shared by LOAD and the arithmetic write-back loop.
// Ports: clk/rst_n; clr_i forces zero; en_i advances (wrapping after NW-1);
// cnt_nxt_o is the value the counter takes at the next edge; last_o flags
// that the current index is NW-1.
module amq_word_cnt
    import amq_ctrl_pkg::*;
#(
    parameter int unsigned NW = NW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [WADDR_W-1:0] cnt_nxt_o,
    output logic               last_o
);

    logic [WADDR_W-1:0] cnt_q;
    logic [WADDR_W-1:0] cnt_d;

    assign last_o = (cnt_q == WADDR_W'(NW - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + WADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/amq_seq_ctrl.sv
// Command sequencer for the 118-bit add/sub-mod-Q datapath.
// Ports: CMD_* host handshake and latched fields; LD_VALID/LD_READY operand
// load handshake; BUSY/DONE/CARRY_OUT status; C_OUT_DPq datapath carry in;
// CARRY_SEL..Qns_ADDR_FINAL drive every datapath control.
// Control outputs are registered from the next state; WE_RAM alone is
// combinational because a LOAD write must follow LD_VALID in the same cycle.
module amq_seq_ctrl
    import amq_ctrl_pkg::*;
#(
    parameter int unsigned NW = NW_DEFAULT
) (
    input  logic       clk,
    input  logic       RST_N,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_OP,
    input  logic [2:0] CMD_RD_OFF,
    input  logic [2:0] CMD_WR_OFF,
    input  logic [4:0] CMD_Q_BASE,
    input  logic       LD_VALID,
    output logic       LD_READY,
    output logic       BUSY,
    output logic       DONE,
    output logic       CARRY_OUT,
    input  logic       C_OUT_DPq,
    output logic       CARRY_SEL,
    output logic       S_REG_RST,
    output logic       S_REG_EN,
    output logic       WB_PHASE,
    output logic       WE_RAM,
    output logic       MEM_CONFIG,
    output logic       ADD_sub,
    output logic [1:0] WB_ADDR,
    output logic [1:0] RAM_ADDR,
    output logic [2:0] WR_VAR_OFFSET,
    output logic [2:0] RD_VAR_OFFSET,
    output logic [4:0] Qns_ADDR_FINAL
);

    state_e               state_q, state_d;
    cmd_t                 cmd_q, cmd_d;
    logic                 accept_c, cnt_en_c, cnt_last;
    logic [WADDR_W-1:0]   cnt_nxt;

    logic                 ready_q, ready_d, ld_ready_q, ld_ready_d, done_q, done_d;
    logic                 csel_q, csel_d, srst_q, srst_d, sen_q, sen_d;
    logic                 wbph_q, wbph_d, mcfg_q, mcfg_d, addsub_q, addsub_d;
    logic                 cout_q, cout_d;
    logic [WADDR_W-1:0]   wb_addr_q, wb_addr_d, ram_addr_q, ram_addr_d;
    logic [QADDR_W-1:0]   qaddr_q, qaddr_d;

    assign accept_c = CMD_VALID && (state_q == ST_IDLE);
    assign cnt_en_c = ((state_q == ST_LOAD) && LD_VALID) ||
                      ((state_q == ST_WB) && !cnt_last);

    amq_word_cnt #(.NW(NW)) u_word_cnt (
        .clk       (clk),
        .rst_n     (RST_N),
        .clr_i     (accept_c),
        .en_i      (cnt_en_c),
        .cnt_nxt_o (cnt_nxt),
        .last_o    (cnt_last)
    );

    // State register.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, latched command fields and next values of registered outputs.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        mcfg_d     = mcfg_q;
        addsub_d   = addsub_q;
        cout_d     = cout_q;
        ram_addr_d = '0;
        qaddr_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    cmd_d = '{op: cmd_op_e'(CMD_OP), rd_off: CMD_RD_OFF,
                              wr_off: CMD_WR_OFF, q_base: CMD_Q_BASE};
                    case (cmd_op_e'(CMD_OP))
                        OP_LOAD: state_d = ST_LOAD;
                        OP_ADDQ: begin state_d = ST_CLR; addsub_d = 1'b1; end
                        OP_SUBQ: begin state_d = ST_CLR; addsub_d = 1'b0; end
                        default: begin state_d = ST_FIN; mcfg_d = !mcfg_q; end
                    endcase
                end
            end
            ST_LOAD:  if (LD_VALID && cnt_last) state_d = ST_FIN;
            ST_CLR:   state_d = ST_FETCH;
            ST_FETCH: state_d = ST_ACC;
            ST_ACC:   state_d = ST_WB;
            ST_WB:    state_d = cnt_last ? ST_FIN : ST_FETCH;
            ST_FIN: begin
                state_d = ST_IDLE;
                if ((cmd_q.op == OP_ADDQ) || (cmd_q.op == OP_SUBQ)) cout_d = C_OUT_DPq;
            end
            default:  state_d = ST_IDLE;
        endcase

        ready_d    = (state_d == ST_IDLE);
        ld_ready_d = (state_d == ST_LOAD);
        done_d     = (state_d == ST_FIN);
        srst_d     = (state_d == ST_CLR);
        sen_d      = (state_d == ST_ACC);
        csel_d     = (state_d == ST_ACC) && (cnt_nxt != '0);
        wbph_d     = (state_d == ST_WB);
        wb_addr_d  = ((state_d == ST_LOAD) || (state_d == ST_WB)) ? cnt_nxt : '0;

        // Word addresses are set on entering FETCH and held through ACC/WB.
        if (state_d == ST_FETCH) begin
            ram_addr_d = cnt_nxt;
            qaddr_d    = cmd_q.q_base + QADDR_W'(cnt_nxt);
        end else if ((state_d == ST_ACC) || (state_d == ST_WB)) begin
            ram_addr_d = ram_addr_q;
            qaddr_d    = qaddr_q;
        end
    end

    // Registered outputs and command context.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            cmd_q      <= '{op: OP_LOAD, rd_off: '0, wr_off: '0, q_base: '0};
            ready_q    <= 1'b1;
            ld_ready_q <= 1'b0;
            done_q     <= 1'b0;
            csel_q     <= 1'b0;
            srst_q     <= 1'b0;
            sen_q      <= 1'b0;
            wbph_q     <= 1'b0;
            mcfg_q     <= 1'b0;
            addsub_q   <= 1'b0;
            cout_q     <= 1'b0;
            wb_addr_q  <= '0;
            ram_addr_q <= '0;
            qaddr_q    <= '0;
        end else begin
            cmd_q      <= cmd_d;
            ready_q    <= ready_d;
            ld_ready_q <= ld_ready_d;
            done_q     <= done_d;
            csel_q     <= csel_d;
            srst_q     <= srst_d;
            sen_q      <= sen_d;
            wbph_q     <= wbph_d;
            mcfg_q     <= mcfg_d;
            addsub_q   <= addsub_d;
            cout_q     <= cout_d;
            wb_addr_q  <= wb_addr_d;
            ram_addr_q <= ram_addr_d;
            qaddr_q    <= qaddr_d;
        end
    end

    assign CMD_READY      = ready_q;
    assign BUSY           = !ready_q;
    assign LD_READY       = ld_ready_q;
    assign DONE           = done_q;
    assign CARRY_OUT      = cout_q;
    assign CARRY_SEL      = csel_q;
    assign S_REG_RST      = srst_q;
    assign S_REG_EN       = sen_q;
    assign WB_PHASE       = wbph_q;
    assign WE_RAM         = (ld_ready_q && LD_VALID) || wbph_q;
    assign MEM_CONFIG     = mcfg_q;
    assign ADD_sub        = addsub_q;
    assign WB_ADDR        = wb_addr_q;
    assign RAM_ADDR       = ram_addr_q;
    assign WR_VAR_OFFSET  = cmd_q.wr_off;
    assign RD_VAR_OFFSET  = cmd_q.rd_off;
    assign Qns_ADDR_FINAL = qaddr_q;

endmodule

// File: doc/amq_seq_ctrl.md
# amq_seq_ctrl

Command-driven sequencer for the 118-bit add/sub-mod-Q datapath (dual RAM banks, Qns ROM, carry-select adder, S/COUT registers). It loads operands, runs a multi-word add or subtract of a RAM operand against a Qns constant with the carry chained across words, and swaps the working and output banks. It sits between the host command interface and one datapath instance, and drives every datapath control input.

## Interface
- NW, 4: words per operand (1..4; RAM_ADDR is 2 bits)
- clk  in  1  clock, all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- CMD_VALID  in  1  command request
- CMD_READY  out  1  high only in IDLE; a command is accepted on VALID&&READY
- CMD_OP  in  2  00 LOAD, 01 ADDQ, 10 SUBQ, 11 SWAP
- CMD_RD_OFF  in  3  read variable offset, latched at accept
- CMD_WR_OFF  in  3  write variable offset, latched at accept
- CMD_Q_BASE  in  5  Qns ROM base address, latched at accept
- LD_VALID  in  1  D_IN word valid during LOAD
- LD_READY  out  1  high in LOAD state
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle pulse at command completion
- CARRY_OUT  out  1  final C_OUT_DPq of the last ADDQ/SUBQ
- C_OUT_DPq  in  1  datapath carry register
- CARRY_SEL, S_REG_RST, S_REG_EN, WB_PHASE, WE_RAM, MEM_CONFIG, ADD_sub  out  1 each  datapath controls
- WB_ADDR, RAM_ADDR  out  2 each  datapath word addresses
- WR_VAR_OFFSET, RD_VAR_OFFSET  out  3 each  latched offsets
- Qns_ADDR_FINAL  out  5  ROM address

## Operation
- States: IDLE, LOAD, CLR, FETCH, ACC, WB, FIN.
- IDLE: all strobes low. On accept: LOAD->LOAD; ADDQ/SUBQ->CLR; SWAP toggles MEM_CONFIG and goes to FIN.
- LOAD: WB_PHASE=0, WE_RAM=LD_VALID, WB_ADDR=word count i. i increments on each LD_VALID. Move to FIN after the NW-th word is written. LD_VALID low stalls the load without a timeout.
- CLR: S_REG_RST=1 for one cycle, i=0.
- FETCH: RAM_ADDR=i and Qns_ADDR_FINAL=(Q_BASE+i) mod 32. The ROM output registers on this edge.
- ACC: addresses held. S_REG_EN=1. CARRY_SEL=0 when i==0, else 1.
- WB: WB_PHASE=1, WE_RAM=1, WB_ADDR=i. If i==NW-1 go to FIN; otherwise i++ and return to FIN's predecessor FETCH.
- ADD_sub is 1 for ADDQ and 0 for SUBQ. It is held constant from CLR through WB.
- FIN: DONE=1. For ADDQ/SUBQ, CARRY_OUT<=C_OUT_DPq. Then return to IDLE.
- MEM_CONFIG changes only on SWAP. Offsets and ADD_sub are held stable for the whole command.
- Address width: RAM word address plus offset wraps in the datapath's 4-bit adders. The controller does not range-check it.

## Timing
- Reset values: state IDLE, i=0, MEM_CONFIG=0, CARRY_OUT=0, DONE=0, every strobe and address 0, CMD_READY=1 once RST_N is high.
- ADDQ/SUBQ latency: accept edge, then 1 CLR + 3*NW + 1 FIN cycles. With NW=4, DONE is high in the 14th cycle after the accept edge.
- SWAP: DONE is high in the cycle after accept. MEM_CONFIG shows the new value in that same cycle.
- LOAD: DONE is high one cycle after the NW-th LD_VALID cycle.
- CMD_VALID while BUSY is ignored, since CMD_READY is low. Back-to-back commands are possible: CMD_READY returns the cycle after FIN.
- Reset mid-command returns to IDLE asynchronously and drops WE_RAM immediately. RAM contents are then undefined. MEM_CONFIG returns to 0.

## Structure
- Package amq_ctrl_pkg holds the state enum, the CMD_OP encodings (LOAD/ADDQ/SUBQ/SWAP) and the NW default.
- One sub-module, amq_word_cnt: a 2-bit word counter with clear, enable and last-flag (i==NW-1), shared by LOAD and WB.

## Test plan
- Reset: hold RST_N=0 → all outputs 0 and CMD_READY=1 after release. Assert RST_N=0 mid-WB → WE_RAM=0 in the same cycle and state IDLE.
- LOAD with NW=4, WR_OFF=2 and LD_VALID gapped as 1,0,1,1,1 → WE_RAM pulses with WB_ADDR=0,1,2,3, WB_PHASE=0, DONE one cycle after the fourth word.
- ADDQ with Q_BASE=30 and NW=4 → Qns_ADDR_FINAL=30,31,0,1; CARRY_SEL=0 on the first ACC and 1 on the rest; 4 WE_RAM pulses with WB_PHASE=1; DONE in cycle 14.
- SUBQ, with a golden model loading operand 0 and all-zero Q → ADD_sub=0 throughout, CARRY_OUT equals the model borrow, and the RAM result matches the model word for word.
- SWAP twice → MEM_CONFIG goes 0→1→0, each DONE is one cycle after accept, and no WE_RAM pulse occurs.
- CMD_VALID held high during ADDQ with a different op → ignored; the second command is accepted only in the cycle after FIN.
